hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It sits between the IF/ID and ID/EX pipeline registers and produces the `ctr_sel` bubble control consumed by the ID/EX register, together with PC and IF/ID write-enable and flush controls. It detects load-use hazards and stalls the front end for a configurable number of cycles. It also squashes wrong-path instructions after a taken branch or jump resolved in EX.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5, register index width.
- `STALL_CYCLES`, 1, load-use stall length; legal range 1–3 (1 with MEM→EX forwarding, 2 without).
- `FLUSH_CYCLES`, 1, redirect squash length; legal range 1–4.
- `CNT_WIDTH`, 32, perf counter width (only with `HAZARD_PERF_CNT_EN`).

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `IF_ID_inst_opcode`  in  7  opcode of instruction in ID.
- `IF_ID_rs1`  in  REG_ADDR_WIDTH  rs1 of instruction in ID.
- `IF_ID_rs2`  in  REG_ADDR_WIDTH  rs2 of instruction in ID.
- `ID_EX_inst_opcode`  in  7  opcode of instruction in EX.
- `ID_EX_rd`  in  REG_ADDR_WIDTH  rd of instruction in EX.
- `ID_EX_pc_sel`  in  1  taken branch/jump resolved in EX.
- `pc_write_en`  out  1  PC register update enable.
- `if_id_write_en`  out  1  IF/ID register load enable.
- `if_id_flush`  out  1  IF/ID register replaced by NOP.
- `ctr_sel`  out  1  1 = pass ID controls into ID/EX, 0 = insert bubble.
- `hz_state`  out  2  FSM state: RUN=0, STALL=1, FLUSH=2.
- `stall_cnt`  out  CNT_WIDTH  stall-cycle count (macro only).
- `flush_cnt`  out  CNT_WIDTH  flush-cycle count (macro only).
- `cnt_clr`  in  1  synchronous counter clear (macro only).

## Operation
- rs1_used = IF_ID opcode not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
- rs2_used = IF_ID opcode in {0110011, 0100011, 1100011}.
- load_use = (ID_EX opcode == 0000011) && ID_EX_rd != 0 && ((rs1_used && rd == rs1) || (rs2_used && rd == rs2)).
- The 3-bit down-counter `cnt` and the state register both reset to RUN / 0.

The FSM is Mealy; outputs are combinational from state and inputs:
- **RUN, ID_EX_pc_sel=1** (has priority over load_use):
  - Outputs: pc_write_en=1, if_id_write_en=1, if_id_flush=1, ctr_sel=0.
  - If FLUSH_CYCLES>1: go to FLUSH with cnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
- **RUN, load_use=1:**
  - Outputs: pc_write_en=0, if_id_write_en=0, if_id_flush=0, ctr_sel=0.
  - If STALL_CYCLES>1: go to STALL with cnt=STALL_CYCLES-1. Otherwise stay in RUN.
- **RUN, otherwise:** pc_write_en=1, if_id_write_en=1, if_id_flush=0, ctr_sel=1.
- **STALL:**
  - Outputs as for load_use.
  - cnt decrements each cycle; when cnt==1, go to RUN.
  - ID_EX_pc_sel and load_use are ignored, because ID/EX holds a bubble.
- **FLUSH:**
  - Outputs as for a redirect.
  - cnt decrements each cycle; when cnt==1, go to RUN.
  - ID_EX_pc_sel is ignored.
- Unused state encoding 3 returns to RUN on the next edge, with RUN outputs.

## Timing
- All outputs are zero-latency: combinational in the same cycle as the hazard inputs.
- State, cnt and counters update only on the rising edge of `clk`.
- While `reset`=1, outputs are forced to pc_write_en=0, if_id_write_en=0, if_id_flush=1, ctr_sel=0, hz_state=0.
- On the first edge with `reset`=1, state=RUN, cnt=0 and the counters are 0.
- Reset asserted mid-STALL or mid-FLUSH aborts the sequence. The first cycle after reset deassertion is RUN.
- Load-use stall: exactly STALL_CYCLES cycles with ctr_sel=0 and the PC/IF_ID frozen. The dependent instruction enters EX on the following cycle.
- Redirect squash: exactly FLUSH_CYCLES cycles with if_id_flush=1. The first cycle is the one in which ID_EX_pc_sel=1.
- Taken redirect and load_use in the same RUN cycle: the redirect wins and no stall occurs.
- ID_EX_rd==0 never causes a stall.

## Configuration
- **`HAZARD_PERF_CNT_EN` defined:**
  - Ports `stall_cnt`, `flush_cnt` and `cnt_clr` exist.
  - `stall_cnt` increments on every edge with ctr_sel=0 && pc_write_en=0.
  - `flush_cnt` increments on every edge with if_id_flush=1 outside reset.
  - Both counters saturate at all-ones.
  - `reset` or `cnt_clr` clears both counters; clear has priority over increment.
- **Undefined:** these ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- **Load-use, default parameters:**
  - Stimulus: ID_EX opcode 0000011, rd=5; IF_ID opcode 0110011, rs2=5.
  - Required: one cycle of ctr_sel=0, pc_write_en=0, if_id_write_en=0, then ctr_sel=1.
- **STALL_CYCLES=2, same stimulus:**
  - Required: hz_state goes 0→1→0.
  - Required: two freeze cycles, with ID_EX_pc_sel=1 injected during STALL ignored.
- **Redirect, FLUSH_CYCLES=3, with ID_EX_pc_sel=1 for one cycle:**
  - Required: if_id_flush=1 for 3 cycles, pc_write_en=1 throughout, hz_state 0→2→2→0.
- **Simultaneous redirect and load_use:**
  - Required: if_id_flush=1, pc_write_en=1, and no STALL entry.
- **No false stalls:**
  - Load with rd=0 → no stall.
  - Load with rd=3 and IF_ID LUI with rs1 field=3 → no stall.
  - Load with rd=3 and IF_ID I-type (0010011) with rs2 field=3 → no stall.
- **Reset mid-FLUSH, then perf counters (macro defined):**
  - `reset`=1 during FLUSH → state RUN the next cycle, stall_cnt=flush_cnt=0.
  - After 2 stalls and 3 flush cycles → stall_cnt=2, flush_cnt=3.
  - Then cnt_clr=1 → both counters 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller for the 5-stage RISC-V core.
//                Detects load-use hazards (front-end stall, ID/EX bubble)
//                and squashes wrong-path fetches after a taken redirect
//                resolved in EX. Mealy outputs, zero-latency.
//  Options     : HAZARD_PERF_CNT_EN adds saturating stall/flush cycle
//                counters (stall_cnt, flush_cnt) with clear input cnt_clr.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int STALL_CYCLES   = 1,
    parameter int FLUSH_CYCLES   = 1
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_WIDTH      = 32
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                IF_ID_inst_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
    input  logic [6:0]                ID_EX_inst_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
    input  logic                      ID_EX_pc_sel,
    output logic                      pc_write_en,
    output logic                      if_id_write_en,
    output logic                      if_id_flush,
    output logic                      ctr_sel,
    output logic [1:0]                hz_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    input  logic                      cnt_clr,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
`endif
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    // Counter preload values; a length of 1 never leaves RUN so the value is unused then.
    localparam logic [2:0] c_STALL_LOAD = 3'(STALL_CYCLES - 1);
    localparam logic [2:0] c_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic w_rs1_used;
    logic w_rs2_used;
    logic w_load_use;

    // Source-register usage of the instruction in ID, and the load-use match against EX.
    always_comb begin
        w_rs1_used = !((IF_ID_inst_opcode == c_OP_LUI)   ||
                       (IF_ID_inst_opcode == c_OP_AUIPC) ||
                       (IF_ID_inst_opcode == c_OP_JAL));
        w_rs2_used =  (IF_ID_inst_opcode == c_OP_RTYPE)  ||
                      (IF_ID_inst_opcode == c_OP_STORE)  ||
                      (IF_ID_inst_opcode == c_OP_BRANCH);
        w_load_use = (ID_EX_inst_opcode == c_OP_LOAD) &&
                     (ID_EX_rd != '0) &&
                     ((w_rs1_used && (ID_EX_rd == IF_ID_rs1)) ||
                      (w_rs2_used && (ID_EX_rd == IF_ID_rs2)));
    end

    // Mealy next-state and output decode; reset overrides the outputs last.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        ctr_sel        = 1'b1;

        case (state_q)
            RUN: begin
                if (ID_EX_pc_sel) begin
                    // Redirect wins over a simultaneous load-use.
                    if_id_flush = 1'b1;
                    ctr_sel     = 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = c_FLUSH_LOAD;
                    end
                end else if (w_load_use) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    ctr_sel        = 1'b0;
                    if (STALL_CYCLES > 1) begin
                        state_d = STALL;
                        cnt_d   = c_STALL_LOAD;
                    end
                end
            end
            STALL: begin
                // EX holds a bubble here, so hazard inputs are not examined.
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                ctr_sel        = 1'b0;
                cnt_d          = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if_id_flush = 1'b1;
                ctr_sel     = 1'b0;
                cnt_d       = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = RUN;
                end
            end
            default: begin
                // Illegal encoding: plain RUN outputs, recover on the next edge.
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase

        if (reset) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            if_id_flush    = 1'b1;
            ctr_sel        = 1'b0;
        end
    end

    // State and sequence-length counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz_state = reset ? 2'b00 : state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_q;

    // Saturating perf counters; clear takes priority over increment.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!ctr_sel && !pc_write_en && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (if_id_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Two instances share the
//                stimulus: A uses default lengths (1/1), B uses STALL_CYCLES=2
//                and FLUSH_CYCLES=3. Expected outputs are queued when a cycle
//                is driven and popped when it is sampled on the falling edge.
//                HAZARD_PERF_CNT_EN enables the counter scenario as well.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    // Expected output vector per instance: {hz_state, pc_we, if_id_we, flush, ctr_sel}
    localparam logic [5:0] E_RUN = 6'b00_1101;
    localparam logic [5:0] E_RED = 6'b00_1110;
    localparam logic [5:0] E_LU  = 6'b00_0000;
    localparam logic [5:0] E_STL = 6'b01_0000;
    localparam logic [5:0] E_FLS = 6'b10_1110;
    localparam logic [5:0] E_RST = 6'b00_0010;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_ST   = 7'b0100011;

    logic       clk;
    logic       rst;
    logic [6:0] if_op;
    logic [4:0] rs1, rs2;
    logic [6:0] ex_op;
    logic [4:0] ex_rd;
    logic       pcs;

    logic       a_pcwe, a_ifwe, a_fl, a_ctr;
    logic [1:0] a_st;
    logic       b_pcwe, b_ifwe, b_fl, b_ctr;
    logic [1:0] b_st;

    logic [11:0] sb[$];
    int n_cmp  = 0;
    int n_fail = 0;

`ifdef HAZARD_PERF_CNT_EN
    logic        cnt_clr;
    logic [31:0] a_sc, a_fc, b_sc, b_fc;
`endif

    hazard_ctrl u_dut_a (
        .clk              (clk),
        .reset            (rst),
        .IF_ID_inst_opcode(if_op),
        .IF_ID_rs1        (rs1),
        .IF_ID_rs2        (rs2),
        .ID_EX_inst_opcode(ex_op),
        .ID_EX_rd         (ex_rd),
        .ID_EX_pc_sel     (pcs),
        .pc_write_en      (a_pcwe),
        .if_id_write_en   (a_ifwe),
        .if_id_flush      (a_fl),
        .ctr_sel          (a_ctr),
        .hz_state         (a_st)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .cnt_clr          (cnt_clr),
        .stall_cnt        (a_sc),
        .flush_cnt        (a_fc)
`endif
    );

    hazard_ctrl #(
        .STALL_CYCLES(2),
        .FLUSH_CYCLES(3)
    ) u_dut_b (
        .clk              (clk),
        .reset            (rst),
        .IF_ID_inst_opcode(if_op),
        .IF_ID_rs1        (rs1),
        .IF_ID_rs2        (rs2),
        .ID_EX_inst_opcode(ex_op),
        .ID_EX_rd         (ex_rd),
        .ID_EX_pc_sel     (pcs),
        .pc_write_en      (b_pcwe),
        .if_id_write_en   (b_ifwe),
        .if_id_flush      (b_fl),
        .ctr_sel          (b_ctr),
        .hz_state         (b_st)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .cnt_clr          (cnt_clr),
        .stall_cnt        (b_sc),
        .flush_cnt        (b_fc)
`endif
    );

    wire [11:0] w_obs = {b_st, b_pcwe, b_ifwe, b_fl, b_ctr,
                         a_st, a_pcwe, a_ifwe, a_fl, a_ctr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [30:0] mk(input logic r, input logic p,
                                       input logic [6:0] io, input logic [4:0] a,
                                       input logic [4:0] b, input logic [6:0] eo,
                                       input logic [4:0] d);
        return {r, p, io, a, b, eo, d};
    endfunction

    function automatic logic [30:0] idle(input logic r, input logic p);
        return mk(r, p, OP_I, 5'd0, 5'd0, OP_I, 5'd0);
    endfunction

    // Apply one cycle of stimulus and queue the outputs it must produce.
    task automatic drive(input logic [30:0] s, input logic [11:0] e);
        {rst, pcs, if_op, rs1, rs2, ex_op, ex_rd} = s;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        logic [30:0] st[3];
        logic [11:0] ex[3];
        logic [11:0] want;
        st = '{idle(1, 0), idle(1, 1), idle(0, 0)};
        ex = '{{E_RST, E_RST}, {E_RST, E_RST}, {E_RUN, E_RUN}};
        for (int i = 0; i < 3; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            want = sb.pop_front();
            n_cmp++;
            if (w_obs !== want) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %b expected %b", i, w_obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        logic [30:0] st[3];
        logic [11:0] ex[3];
        logic [11:0] want;
        st = '{mk(0, 0, OP_R, 5'd1, 5'd5, OP_LOAD, 5'd5),
               mk(0, 1, OP_R, 5'd1, 5'd5, 7'd0, 5'd0),
               mk(0, 0, OP_I, 5'd0, 5'd0, OP_R, 5'd7)};
        ex = '{{E_LU, E_LU}, {E_STL, E_RED}, {E_RUN, E_RUN}};
        for (int i = 0; i < 3; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            want = sb.pop_front();
            n_cmp++;
            if (w_obs !== want) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got %b expected %b", i, w_obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        logic [30:0] st[4];
        logic [11:0] ex[4];
        logic [11:0] want;
        st = '{idle(0, 1), idle(0, 0), idle(0, 0), idle(0, 0)};
        ex = '{{E_RED, E_RED}, {E_FLS, E_RUN}, {E_FLS, E_RUN}, {E_RUN, E_RUN}};
        for (int i = 0; i < 4; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            want = sb.pop_front();
            n_cmp++;
            if (w_obs !== want) begin
                n_fail++;
                $display("FAIL redirect[%0d]: got %b expected %b", i, w_obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect_vs_load_use();
        logic [30:0] st[4];
        logic [11:0] ex[4];
        logic [11:0] want;
        st = '{mk(0, 1, OP_R, 5'd5, 5'd2, OP_LOAD, 5'd5),
               idle(0, 0), idle(0, 0), idle(0, 0)};
        ex = '{{E_RED, E_RED}, {E_FLS, E_RUN}, {E_FLS, E_RUN}, {E_RUN, E_RUN}};
        for (int i = 0; i < 4; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            want = sb.pop_front();
            n_cmp++;
            if (w_obs !== want) begin
                n_fail++;
                $display("FAIL redir_vs_lu[%0d]: got %b expected %b", i, w_obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_no_false_stall();
        logic [30:0] st[6];
        logic [11:0] ex[6];
        logic [11:0] want;
        st = '{mk(0, 0, OP_R,   5'd0, 5'd0, OP_LOAD, 5'd0),
               mk(0, 0, OP_LUI, 5'd3, 5'd3, OP_LOAD, 5'd3),
               mk(0, 0, OP_I,   5'd1, 5'd3, OP_LOAD, 5'd3),
               mk(0, 0, OP_ST,  5'd1, 5'd3, OP_LOAD, 5'd3),
               idle(0, 0), idle(0, 0)};
        ex = '{{E_RUN, E_RUN}, {E_RUN, E_RUN}, {E_RUN, E_RUN},
               {E_LU, E_LU}, {E_STL, E_RUN}, {E_RUN, E_RUN}};
        for (int i = 0; i < 6; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            want = sb.pop_front();
            n_cmp++;
            if (w_obs !== want) begin
                n_fail++;
                $display("FAIL no_false_stall[%0d]: got %b expected %b", i, w_obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_flush();
        logic [30:0] st[4];
        logic [11:0] ex[4];
        logic [11:0] want;
        st = '{idle(0, 1), idle(0, 0), idle(1, 0), idle(0, 0)};
        ex = '{{E_RED, E_RED}, {E_FLS, E_RUN}, {E_RST, E_RST}, {E_RUN, E_RUN}};
        for (int i = 0; i < 4; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            want = sb.pop_front();
            n_cmp++;
            if (w_obs !== want) begin
                n_fail++;
                $display("FAIL reset_mid_flush[%0d]: got %b expected %b", i, w_obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_cnt();
        logic [30:0] st[9];
        logic [11:0] ex[9];
        logic [31:0] esc[9];
        logic [31:0] efc[9];
        logic [11:0] want;
        st  = '{idle(1, 0), idle(0, 0),
                mk(0, 0, OP_R, 5'd5, 5'd1, OP_LOAD, 5'd5),
                mk(0, 0, OP_R, 5'd5, 5'd1, OP_LOAD, 5'd5),
                idle(0, 1), idle(0, 1), idle(0, 1), idle(0, 0), idle(0, 0)};
        ex  = '{{E_RST, E_RST}, {E_RUN, E_RUN}, {E_LU, E_LU}, {E_STL, E_LU},
                {E_RED, E_RED}, {E_FLS, E_RED}, {E_FLS, E_RED},
                {E_RUN, E_RUN}, {E_RUN, E_RUN}};
        esc = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd2, 32'd2, 32'd2, 32'd0};
        efc = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        for (int i = 0; i < 9; i++) begin
            drive(st[i], ex[i]);
            cnt_clr = (i == 7);
            @(negedge clk);
            want = sb.pop_front();
            n_cmp++;
            if (w_obs !== want) begin
                n_fail++;
                $display("FAIL perf_out[%0d]: got %b expected %b", i, w_obs, want);
            end
            if (i > 0) begin
                n_cmp++;
                if ({a_sc, a_fc, b_sc, b_fc} !== {esc[i], efc[i], esc[i], efc[i]}) begin
                    n_fail++;
                    $display("FAIL perf_cnt[%0d]: got A=%0d/%0d B=%0d/%0d expected %0d/%0d",
                             i, a_sc, a_fc, b_sc, b_fc, esc[i], efc[i]);
                end
            end
            @(posedge clk); #1;
        end
        cnt_clr = 1'b0;
    endtask
`endif

    initial begin
`ifdef HAZARD_PERF_CNT_EN
        cnt_clr = 1'b0;
`endif
        {rst, pcs, if_op, rs1, rs2, ex_op, ex_rd} = idle(1, 0);
        test_reset();
        test_load_use();
        test_redirect();
        test_redirect_vs_load_use();
        test_no_false_stall();
        test_reset_mid_flush();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
